quiz_display_seq: RTL and testbench



---
 rtl/quiz_display_if.sv | 23 ++
 rtl/quiz_display_seq.sv | 158 +++++++++++++++
 tb/tb_quiz_display_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/quiz_display_if.sv
// Question/display bus between the quiz generator (master) and the display sequencer (slave).
interface quiz_display_if;
    logic       tick;
    logic       start;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic [1:0] op;
    logic [6:0] result;
    logic       busy;
    logic       done;
    logic [6:0] seg_ones;
    logic [6:0] seg_tens;

    modport master (
        output tick, start, operand_a, operand_b, op, result,
        input  busy, done, seg_ones, seg_tens
    );

    modport slave (
        input  tick, start, operand_a, operand_b, op, result,
        output busy, done, seg_ones, seg_tens
    );
endinterface

// File: rtl/quiz_display_seq.sv
// Plays one quiz question (A, operator, B, result) on a two-digit seven-segment display.
// Define QUIZ_DISP_GAP_EN to insert a blank frame between consecutive SHOW frames.
module quiz_display_seq #(
    parameter int unsigned HOLD_TICKS = 3
) (
    input  logic           clk,
    input  logic           reset,
    quiz_display_if.slave  bus
);

`ifdef QUIZ_DISP_GAP_EN
    typedef enum logic [2:0] {IDLE, SHOW_A, GAP_A, SHOW_OP, GAP_OP, SHOW_B, GAP_B, SHOW_RES} state_t;
`else
    typedef enum logic [2:0] {IDLE, SHOW_A, SHOW_OP, SHOW_B, SHOW_RES} state_t;
`endif

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
    localparam logic [6:0] GLYPH_E     = 7'b1001111;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 7'b1111110;
            4'd1:    digit_glyph = 7'b0110000;
            4'd2:    digit_glyph = 7'b1101101;
            4'd3:    digit_glyph = 7'b1111001;
            4'd4:    digit_glyph = 7'b0110011;
            4'd5:    digit_glyph = 7'b1011011;
            4'd6:    digit_glyph = 7'b1011111;
            4'd7:    digit_glyph = 7'b1110000;
            4'd8:    digit_glyph = 7'b1111111;
            4'd9:    digit_glyph = 7'b1111011;
            default: digit_glyph = GLYPH_E;
        endcase
    endfunction

    function automatic logic [6:0] op_glyph(input logic [1:0] o);
        case (o)
            2'd0:    op_glyph = 7'b1110111;
            2'd1:    op_glyph = 7'b0000001;
            2'd2:    op_glyph = 7'b0110111;
            default: op_glyph = GLYPH_E;
        endcase
    endfunction

    state_t     state, state_n, succ;
    logic [3:0] hold_cnt, hold_n;
    logic [3:0] lat_a, lat_a_n, lat_b, lat_b_n;
    logic [1:0] lat_op, lat_op_n;
    logic [6:0] lat_res, lat_res_n;
    logic       busy_q, busy_n, done_q, done_n;
    logic [6:0] ones_q, ones_n, tens_q, tens_n;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_op   <= '0;
            lat_res  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ones_q   <= GLYPH_BLANK;
            tens_q   <= GLYPH_BLANK;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            lat_a    <= lat_a_n;
            lat_b    <= lat_b_n;
            lat_op   <= lat_op_n;
            lat_res  <= lat_res_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            ones_q   <= ones_n;
            tens_q   <= tens_n;
        end
    end

    // Frame order; gap frames only exist when the feature is built in.
    always_comb begin
        succ = IDLE;
        case (state)
`ifdef QUIZ_DISP_GAP_EN
            SHOW_A:   succ = GAP_A;
            GAP_A:    succ = SHOW_OP;
            SHOW_OP:  succ = GAP_OP;
            GAP_OP:   succ = SHOW_B;
            SHOW_B:   succ = GAP_B;
            GAP_B:    succ = SHOW_RES;
`else
            SHOW_A:   succ = SHOW_OP;
            SHOW_OP:  succ = SHOW_B;
            SHOW_B:   succ = SHOW_RES;
`endif
            default:  succ = IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        lat_a_n   = lat_a;
        lat_b_n   = lat_b;
        lat_op_n  = lat_op;
        lat_res_n = lat_res;
        done_n    = 1'b0;

        if (state == IDLE) begin
            if (bus.start) begin
                lat_a_n   = bus.operand_a;
                lat_b_n   = bus.operand_b;
                lat_op_n  = bus.op;
                lat_res_n = bus.result;
                state_n   = SHOW_A;
                hold_n    = '0;
            end
        end else if (bus.tick) begin
            if (hold_cnt == HOLD_LAST) begin
                state_n = succ;
                hold_n  = '0;
                done_n  = (state == SHOW_RES);
            end else begin
                hold_n = hold_cnt + 4'd1;
            end
        end

        // Glyphs are derived from the next state so segments change on the same edge as the state.
        busy_n = (state_n != IDLE);
        ones_n = GLYPH_BLANK;
        tens_n = GLYPH_BLANK;
        case (state_n)
            SHOW_A:  ones_n = digit_glyph(lat_a_n);
            SHOW_OP: ones_n = op_glyph(lat_op_n);
            SHOW_B:  ones_n = digit_glyph(lat_b_n);
            SHOW_RES: begin
                if (lat_res_n < 7'd10) begin
                    ones_n = digit_glyph(lat_res_n[3:0]);
                end else if (lat_res_n < 7'd100) begin
                    tens_n = digit_glyph(4'(lat_res_n / 7'd10));
                    ones_n = digit_glyph(4'(lat_res_n % 7'd10));
                end else begin
                    tens_n = GLYPH_E;
                    ones_n = GLYPH_E;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.seg_ones = ones_q;
    assign bus.seg_tens = tens_q;

endmodule

// File: tb/tb_quiz_display_seq.sv
// Directed, table-driven bench for quiz_display_seq (frame glyphs, timing, abort and restart).
module tb_quiz_display_seq;

    localparam int H = 3;
`ifdef QUIZ_DISP_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif
    localparam int NF = GAP ? 7 : 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [6:0] res;
        logic [6:0] ga;
        logic [6:0] gop;
        logic [6:0] gb;
        logic [6:0] gres_t;
        logic [6:0] gres_o;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   seq_expected = 0;
    vec_t vecs[6];

    quiz_display_if bus ();

    quiz_display_seq #(.HOLD_TICKS(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_ones(input vec_t v, input int f);
        int s;
        if (GAP && (f % 2 == 1)) return 7'b0;
        s = GAP ? f / 2 : f;
        case (s)
            0:       return v.ga;
            1:       return v.gop;
            2:       return v.gb;
            default: return v.gres_o;
        endcase
    endfunction

    function automatic logic [6:0] exp_tens(input vec_t v, input int f);
        return (f == NF - 1) ? v.gres_t : 7'b0;
    endfunction

    task automatic start_vec(input vec_t v, input bit with_tick);
        bus.operand_a = v.a;
        bus.operand_b = v.b;
        bus.op        = v.op;
        bus.result    = v.res;
        bus.start     = 1'b1;
        bus.tick      = with_tick;
        cycle();
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_done", 32'(bus.done), 32'd0);
        check("start_ones", 32'(bus.seg_ones), 32'(v.ga));
        check("start_tens", 32'(bus.seg_tens), 32'd0);
    endtask

    // Ends right after the completing edge, i.e. inside the done cycle.
    task automatic play_vec(input vec_t v, input bit disturb, input bit cont);
        int f;
        for (int k = 1; k <= NF * H; k++) begin
            bus.tick = 1'b1;
            cycle();
            if (!cont) bus.tick = 1'b0;
            if (k < NF * H) begin
                f = k / H;
                check($sformatf("ones_k%0d", k), 32'(bus.seg_ones), 32'(exp_ones(v, f)));
                check($sformatf("tens_k%0d", k), 32'(bus.seg_tens), 32'(exp_tens(v, f)));
                check($sformatf("busy_k%0d", k), 32'(bus.busy), 32'd1);
                check($sformatf("nodone_k%0d", k), 32'(bus.done), 32'd0);
                if (disturb && f == (GAP ? 4 : 2) && (k % H == 0)) begin
                    bus.start     = 1'b1;
                    bus.operand_a = 4'd1;
                    bus.operand_b = 4'd6;
                    bus.op        = 2'd3;
                    bus.result    = 7'd55;
                    cycle();
                    bus.start = 1'b0;
                end
                if (!cont) cycle();
            end else begin
                check("end_done", 32'(bus.done), 32'd1);
                check("end_busy", 32'(bus.busy), 32'd0);
                check("end_ones", 32'(bus.seg_ones), 32'd0);
                check("end_tens", 32'(bus.seg_tens), 32'd0);
            end
        end
        bus.tick = 1'b0;
        seq_expected++;
    endtask

    initial begin
        vecs[0] = '{a:4'd7,  b:4'd2, op:2'd0, res:7'd9,   ga:7'b1110000, gop:7'b1110111, gb:7'b1101101, gres_t:7'b0000000, gres_o:7'b1111011};
        vecs[1] = '{a:4'd9,  b:4'd9, op:2'd2, res:7'd81,  ga:7'b1111011, gop:7'b0110111, gb:7'b1111011, gres_t:7'b1111111, gres_o:7'b0110000};
        vecs[2] = '{a:4'd4,  b:4'd5, op:2'd1, res:7'd100, ga:7'b0110011, gop:7'b0000001, gb:7'b1011011, gres_t:7'b1001111, gres_o:7'b1001111};
        vecs[3] = '{a:4'd12, b:4'd0, op:2'd3, res:7'd10,  ga:7'b1001111, gop:7'b1001111, gb:7'b1111110, gres_t:7'b0110000, gres_o:7'b1111110};
        vecs[4] = '{a:4'd0,  b:4'd8, op:2'd1, res:7'd127, ga:7'b1111110, gop:7'b0000001, gb:7'b1111111, gres_t:7'b1001111, gres_o:7'b1001111};
        vecs[5] = '{a:4'd3,  b:4'd3, op:2'd2, res:7'd0,   ga:7'b1111001, gop:7'b0110111, gb:7'b1111001, gres_t:7'b0000000, gres_o:7'b1111110};

        bus.tick = 1'b0;
        bus.start = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.op = '0;
        bus.result = '0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        cycle();

        // Idle with ticks but no start.
        for (int i = 0; i < 20; i++) begin
            bus.tick = 1'b1;
            cycle();
            bus.tick = 1'b0;
            cycle();
        end
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_ones", 32'(bus.seg_ones), 32'd0);
        check("idle_tens", 32'(bus.seg_tens), 32'd0);

        // Back-to-back table: each new start lands in the previous done cycle.
        // vec1 has a tick on the start edge, vec2 sees a start and input churn during SHOW_B,
        // vec3 runs with tick held high.
        for (int i = 0; i < 6; i++) begin
            start_vec(vecs[i], i == 1);
            play_vec(vecs[i], i == 2, i == 3);
        end
        cycle();
        check("after_table_done", 32'(bus.done), 32'd0);
        check("after_table_busy", 32'(bus.busy), 32'd0);

        // Reset while SHOW_OP is displayed.
        start_vec(vecs[0], 1'b0);
        for (int k = 0; k < H; k++) begin
            bus.tick = 1'b1;
            cycle();
            bus.tick = 1'b0;
            cycle();
        end
        check("pre_reset_ones", 32'(bus.seg_ones), 32'(vecs[0].gop));
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ones", 32'(bus.seg_ones), 32'd0);
        check("rst_tens", 32'(bus.seg_tens), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        cycle();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        start_vec(vecs[1], 1'b0);
        play_vec(vecs[1], 1'b0, 1'b0);
        cycle();
        check("final_done_low", 32'(bus.done), 32'd0);
        repeat (2) cycle();
        check("done_pulse_count", 32'(done_cnt), 32'(seq_expected));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence never completes.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
